// File: rtl/carfield_dyn_addr_decoder.sv
// Runtime-programmable address decoder: NumRules {base,size} windows behind a 32-bit
// config port, decoding through one valid/ready output register with a saturating miss counter.
module carfield_dyn_addr_decoder #(
    parameter int unsigned NumRules   = 8,
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned IdxWidth   = (NumRules > 1) ? $clog2(NumRules) : 1,
    parameter int unsigned DefaultIdx = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [11:0]          cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [31:0]          cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic [AddrWidth-1:0] dec_addr_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [IdxWidth-1:0]  res_idx_o,
    output logic                 res_err_o
);
    localparam int unsigned HiW      = AddrWidth - 32;
    localparam logic [9:0]  RuleLast = 10'(4 + 4 * NumRules);

    logic [AddrWidth-1:0] r_base [NumRules];
    logic [AddrWidth-1:0] r_size [NumRules];
    logic [NumRules-1:0]  r_enable;
    logic                 r_lock;
    logic [15:0]          r_misscnt;
    logic                 r_cfg_rvalid, r_cfg_err;
    logic [31:0]          r_cfg_rdata;
    logic                 r_res_valid, r_res_err;
    logic [IdxWidth-1:0]  r_res_idx;

    logic [9:0]           w_word, w_roff;
    logic [IdxWidth-1:0]  w_rsel;
    logic [1:0]           w_sub;
    logic                 w_is_en, w_is_lock, w_is_cnt, w_is_rule, w_mapped;
    logic                 w_err, w_wr_ok;
    logic [31:0]          w_rd;
    logic [NumRules-1:0]  w_match;
    logic                 w_hit, w_accept;
    logic [IdxWidth-1:0]  w_idx;
    logic                 w_unused;

    assign w_word    = cfg_addr_i[11:2];
    assign w_roff    = w_word - 10'd4;
    assign w_rsel    = w_roff[IdxWidth+1:2];
    assign w_sub     = w_roff[1:0];
    assign w_is_en   = (w_word == 10'd0);
    assign w_is_lock = (w_word == 10'd1);
    assign w_is_cnt  = (w_word == 10'd2);
    assign w_is_rule = (w_word >= 10'd4) && (w_word < RuleLast);
    assign w_mapped  = w_is_en | w_is_lock | w_is_cnt | w_is_rule;
    // MISSCNT stays writable under lock so software can still clear it.
    assign w_err     = !w_mapped || (cfg_we_i && r_lock && (w_is_en | w_is_lock | w_is_rule));
    assign w_wr_ok   = cfg_req_i && cfg_we_i && !w_err;
    assign w_unused  = ^{cfg_addr_i[1:0], w_roff[9:IdxWidth+2]};

    always_comb begin
        w_rd = '0;
        if (w_is_en) begin
            w_rd[NumRules-1:0] = r_enable;
        end else if (w_is_lock) begin
            w_rd[0] = r_lock;
        end else if (w_is_cnt) begin
            w_rd[15:0] = r_misscnt;
        end else if (w_is_rule) begin
            case (w_sub)
                2'd0:    w_rd            = r_base[w_rsel][31:0];
                2'd1:    w_rd[HiW-1:0]   = r_base[w_rsel][AddrWidth-1:32];
                2'd2:    w_rd            = r_size[w_rsel][31:0];
                default: w_rd[HiW-1:0]   = r_size[w_rsel][AddrWidth-1:32];
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_cfg_rvalid <= cfg_req_i;
            r_cfg_err    <= cfg_req_i && w_err;
            r_cfg_rdata  <= (cfg_req_i && !cfg_we_i && !w_err) ? w_rd : 32'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRules; i++) begin
                r_base[i] <= '0;
                r_size[i] <= '0;
            end
            r_enable <= '0;
            r_lock   <= 1'b0;
        end else if (w_wr_ok) begin
            if (w_is_en)   r_enable <= cfg_wdata_i[NumRules-1:0];
            if (w_is_lock) r_lock   <= r_lock | cfg_wdata_i[0];
            if (w_is_rule) begin
                case (w_sub)
                    2'd0:    r_base[w_rsel][31:0]           <= cfg_wdata_i;
                    2'd1:    r_base[w_rsel][AddrWidth-1:32] <= cfg_wdata_i[HiW-1:0];
                    2'd2:    r_size[w_rsel][31:0]           <= cfg_wdata_i;
                    default: r_size[w_rsel][AddrWidth-1:32] <= cfg_wdata_i[HiW-1:0];
                endcase
            end
        end
    end

    // Subtraction only happens once addr >= base, so the window never wraps past 2^AddrWidth.
    for (genvar g = 0; g < NumRules; g++) begin : g_match
        assign w_match[g] = r_enable[g] && (r_size[g] != '0) && (dec_addr_i >= r_base[g])
                            && ((dec_addr_i - r_base[g]) < r_size[g]);
    end

    always_comb begin
        w_hit = 1'b0;
        w_idx = IdxWidth'(DefaultIdx);
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_idx = IdxWidth'(i);
            end
        end
    end

    assign dec_ready_o = !r_res_valid || res_ready_i;
    assign w_accept    = dec_valid_i && dec_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_err   <= 1'b0;
        end else if (w_accept) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= w_idx;
            r_res_err   <= !w_hit;
        end else if (res_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_misscnt <= '0;
        end else if (w_wr_ok && w_is_cnt) begin
            r_misscnt <= '0;
        end else if (w_accept && !w_hit && (r_misscnt != 16'hFFFF)) begin
            r_misscnt <= r_misscnt + 16'd1;
        end
    end

    assign cfg_rvalid_o = r_cfg_rvalid;
    assign cfg_rdata_o  = r_cfg_rdata;
    assign cfg_err_o    = r_cfg_err;
    assign res_valid_o  = r_res_valid;
    assign res_idx_o    = r_res_idx;
    assign res_err_o    = r_res_err;
endmodule

// File: doc/carfield_dyn_addr_decoder.md
Name: carfield_dyn_addr_decoder

Overview:
- Runtime-programmable address decoder; replaces the fixed compile-time base/size/enable map for SoC subsystems (L2 ports, islands, clusters, mailbox, peripherals).
- Holds NumRules programmable {base, size} windows plus an enable mask and a sticky lock, all written over a 32-bit register interface.
- Decodes request addresses through one registered valid/ready stage into a target index or a decode error, and counts misses.

Parameters:
- NumRules, 8, number of address windows; rule i maps to target index i.
- AddrWidth, 48, decoded address width, range 33..64.
- IdxWidth, $clog2(NumRules), width of the target index.
- DefaultIdx, 0, index reported on a miss.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_req_i  in  1  config access strobe
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  12  byte offset, word aligned; bits [1:0] ignored
- cfg_wdata_i  in  32  write data
- cfg_rvalid_o  out  1  response valid, one cycle after cfg_req_i
- cfg_rdata_o  out  32  read data, qualified by cfg_rvalid_o
- cfg_err_o  out  1  access error, qualified by cfg_rvalid_o
- dec_valid_i  in  1  decode request valid
- dec_ready_o  out  1  decode request ready
- dec_addr_i  in  AddrWidth  address to decode
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed
- res_idx_o  out  IdxWidth  target index
- res_err_o  out  1  no enabled window matched

Behaviour:
- Register map (byte offsets):
  - 0x000 ENABLE: bits [NumRules-1:0] enable the rules.
  - 0x004 LOCK: bit0, write-1-sets, sticky until reset.
  - 0x008 MISSCNT: 16-bit saturating miss counter; any write clears it.
  - 0x010 + 0x10*i: rule i BASE_LO, BASE_HI, SIZE_LO, SIZE_HI.
  - HI-word bits at or above AddrWidth are ignored on write and read as 0.
- Reset: all rules, ENABLE, LOCK and MISSCNT are 0. cfg_rvalid_o, cfg_rdata_o, cfg_err_o, res_valid_o, res_idx_o and res_err_o are 0.
- Config response: registered, exactly 1 cycle after cfg_req_i.
  - Reads return the register value.
  - Unmapped offsets: cfg_err_o=1, rdata=0, no state change.
- Lock: while LOCK=1, writes to ENABLE, LOCK and rule registers are ignored and return cfg_err_o=1. MISSCNT stays clearable. Reads are always allowed.
- Config write timing: a config write takes effect from the cycle after cfg_req_i. A decode accepted in the same cycle as the write uses the old table.
- Match rule i: ENABLE[i] && size_i!=0 && addr>=base_i && (addr-base_i)<size_i.
  - Compare in AddrWidth bits, with no wrap-around past 2^AddrWidth.
  - size 0 means the rule is disabled.
- Priority: when windows overlap, the lowest matching index wins.
- Miss: res_err_o=1, res_idx_o=DefaultIdx. MISSCNT increments on acceptance and saturates at 0xFFFF.
- Simultaneous miss-increment and MISSCNT write in one cycle: the clear wins, giving 0.
- Pipeline: single output register.
  - dec_ready_o = !res_valid_o || res_ready_i.
  - A request is accepted on dec_valid_i && dec_ready_o.
  - Result appears the next cycle with res_valid_o=1.
  - The result holds stable while res_valid_o && !res_ready_i.
  - Full throughput of 1 per cycle when res_ready_i is held high.
- Reset mid-operation: an in-flight result is dropped, res_valid_o=0 immediately, and the table returns to reset values.

Test Plan:
- Reset, read ENABLE/LOCK/MISSCNT -> all 0; decode 0x7800_0000 -> res_err_o=1, res_idx_o=0, MISSCNT=1.
- Rule1 base 0x7800_0000 size 0x20_0000, rule2 base 0x7820_0000 size 0x20_0000, ENABLE=0x6:
  - decode 0x781F_FFFF -> idx 1;
  - decode 0x7820_0000 -> idx 2;
  - decode 0x7840_0000 -> err.
- Overlap: rule0 and rule3 both cover 0x5000_0000, ENABLE=0x9 -> idx 0; clear ENABLE[0] -> idx 3.
- LOCK=1, then write rule1 BASE_LO -> cfg_err_o=1 and the value is unchanged; MISSCNT write still clears it to 0.
- Backpressure: hold res_ready_i=0 for 3 cycles with dec_valid_i=1 -> dec_ready_o=0, result stable; release -> one result per cycle with no loss or duplication.
- 65,536 misses -> MISSCNT saturates at 0xFFFF; assert reset while res_valid_o=1 -> res_valid_o=0 immediately.
